// File: rtl/mpu_pkg.sv
// Shared opcode constants, classes and scheduler state for the MPU
// instruction scheduler.
package mpu_pkg;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_LOAD   = 4'h4;
   localparam logic [3:0] OP_COPY   = 4'h5;
   localparam logic [3:0] OP_UNLOAD = 4'h6;
   localparam logic [3:0] OP_CLEAR  = 4'h7;
   localparam logic [3:0] OP_ADD    = 4'hC;
   localparam logic [3:0] OP_SHIFT  = 4'hD;
   localparam logic [3:0] OP_SUB    = 4'hE;
   localparam logic [3:0] OP_MULT   = 4'hF;

   localparam logic [3:0] ILLEGAL_MASK = 4'hC;
   localparam logic [3:0] ILLEGAL_VAL  = 4'h8;

   localparam int BURST_LEN_DEF = 64;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      HOLD,
      GAP
   } sched_state_e;

   typedef enum logic [1:0] {
      CLS_NOP,
      CLS_ILLEGAL,
      CLS_SHORT,
      CLS_BURST
   } op_class_e;

   // 00xx has no defined operation and is treated as NOP
   function automatic op_class_e op_class(input logic [3:0] op);
      op_class_e c;
      c = CLS_SHORT;
      unique case (1'b1)
         ((op & ILLEGAL_MASK) == ILLEGAL_VAL): c = CLS_ILLEGAL;
         (op == OP_LOAD || op == OP_UNLOAD):   c = CLS_BURST;
         (op[3:2] == 2'b00):                   c = CLS_NOP;
         default:                              c = CLS_SHORT;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mpu_cmd_fifo.sv
// Synchronous instruction FIFO; push and pop may coincide, also when full.
// Read data is the current head, valid while not empty.
module mpu_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mpu_instr_sched.sv
// Issues buffered host instructions to the MPU control FSM one at a time.
// Optional perf counters: define MPU_SCHED_PERF_CNT_EN.
module mpu_instr_sched
   import mpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BURST_LEN  = BURST_LEN_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_instr,
   output logic        cmd_ready,
   input  logic        fsm_busy,
   output logic [7:0]  host_instruction,
   output logic        beat_valid,
   output logic [5:0]  beat_idx,
   output logic        sched_idle,
   output logic        illegal_pulse
`ifdef MPU_SCHED_PERF_CNT_EN
   ,
   output logic [15:0] ops_issued,
   output logic [15:0] stall_cycles
`endif
);

   localparam logic [5:0] LAST = 6'(BURST_LEN - 1);

   sched_state_e state_q;
   sched_state_e state_d;

   logic [7:0]  fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic        fifo_push;
   logic        fifo_pop;

   op_class_e   cmd_cls;
   logic [7:0]  cur_instr;
   logic        cur_burst;
   logic [5:0]  hold_cnt;

   assign cmd_ready = !fifo_full;
   assign cmd_cls   = op_class(cmd_instr[3:0]);
   assign fifo_push = cmd_valid && cmd_ready &&
                      (cmd_cls == CLS_SHORT || cmd_cls == CLS_BURST);

   mpu_cmd_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (cmd_instr),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         IDLE:  if (!fifo_empty && !fsm_busy) state_d = ISSUE;
         ISSUE: begin
            fifo_pop = 1'b1;
            state_d  = HOLD;
         end
         HOLD:  if (hold_cnt == '0) state_d = GAP;
         GAP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the current state, so the FSM sees
   // each phase one cycle after the scheduler enters it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         cur_instr        <= 8'h00;
         cur_burst        <= 1'b0;
         hold_cnt         <= '0;
         host_instruction <= 8'h00;
         beat_valid       <= 1'b0;
         beat_idx         <= '0;
         sched_idle       <= 1'b1;
         illegal_pulse    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ISSUE) begin
            cur_instr <= fifo_head;
            cur_burst <= (op_class(fifo_head[3:0]) == CLS_BURST);
            hold_cnt  <= (op_class(fifo_head[3:0]) == CLS_BURST) ?
                         LAST : 6'd0;
         end else if (state_q == HOLD && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
         unique case (state_q)
            ISSUE:   host_instruction <= fifo_head;
            HOLD:    host_instruction <= cur_instr;
            default: host_instruction <= OP_NOP;
         endcase
         beat_valid    <= (state_q == HOLD) && cur_burst;
         beat_idx      <= ((state_q == HOLD) && cur_burst) ?
                          LAST - hold_cnt : 6'd0;
         sched_idle    <= (fifo_count == '0) && (state_q == IDLE);
         illegal_pulse <= cmd_valid && cmd_ready &&
                          (cmd_cls == CLS_ILLEGAL);
      end
   end

`ifdef MPU_SCHED_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         ops_issued   <= '0;
         stall_cycles <= '0;
      end else begin
         if (state_q == ISSUE && ops_issued != 16'hFFFF)
            ops_issued <= ops_issued + 1'b1;
         if (state_q == IDLE && !fifo_empty && fsm_busy &&
             stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mpu_instr_sched.sv
// Self-checking bench for mpu_instr_sched against a position-based
// reference model of the issue schedule.
module tb_mpu_instr_sched;

   localparam int DEPTH = 4;
   localparam int BL    = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_instr = 8'h00;
   logic       fsm_busy = 1'b0;
   logic       cmd_ready;
   logic [7:0] host_instruction;
   logic       beat_valid;
   logic [5:0] beat_idx;
   logic       sched_idle;
   logic       illegal_pulse;
`ifdef MPU_SCHED_PERF_CNT_EN
   logic [15:0] ops_issued;
   logic [15:0] stall_cycles;
`endif

   mpu_instr_sched #(
      .FIFO_DEPTH (DEPTH),
      .BURST_LEN  (BL)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_instr        (cmd_instr),
      .cmd_ready        (cmd_ready),
      .fsm_busy         (fsm_busy),
      .host_instruction (host_instruction),
      .beat_valid       (beat_valid),
      .beat_idx         (beat_idx),
      .sched_idle       (sched_idle),
      .illegal_pulse    (illegal_pulse)
`ifdef MPU_SCHED_PERF_CNT_EN
      ,
      .ops_issued       (ops_issued),
      .stall_cycles     (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Model: pos = -1 when waiting, else cycle offset since issue start
   // (0 issue, 1..len held, len+1 gap).
   logic [7:0]  mq [$];
   int          pos = -1;
   int          mlen = 1;
   logic [7:0]  minstr = 8'h00;
   logic [17:0] exp_vec = 18'h0;
   wire  [17:0] dut_vec = {host_instruction, cmd_ready, beat_valid,
                           beat_idx, sched_idle, illegal_pulse};

   // 0 nop, 1 illegal, 2 short, 3 burst
   function automatic int cls(input logic [7:0] i);
      logic [3:0] op;
      op = i[3:0];
      if (op[3:2] == 2'b10) return 1;
      if (op == 4'h4 || op == 4'h6) return 3;
      if (op[3:2] == 2'b00) return 0;
      return 2;
   endfunction

   task automatic model_step();
      int sz;
      bit rdy, e_idle, e_bv, e_ill;
      logic [7:0] e_host;
      logic [5:0] e_bi;
      int c;
      if (reset) begin
         mq.delete();
         pos = -1;
         exp_vec = {8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0};
         return;
      end
      sz = mq.size();
      rdy = (sz < DEPTH);
      e_idle = (pos < 0) && (sz == 0);
      if (pos == 0) begin
         minstr = mq.pop_front();
         mlen = (cls(minstr) == 3) ? BL : 1;
      end
      e_host = (pos >= 0 && pos <= mlen) ? minstr : 8'h00;
      e_bv = (cls(minstr) == 3) && pos >= 1 && pos <= mlen;
      e_bi = e_bv ? 6'(pos - 1) : 6'd0;
      if (pos < 0) begin
         if (sz > 0 && !fsm_busy) pos = 0;
      end else if (pos > mlen) begin
         pos = -1;
      end else begin
         pos++;
      end
      e_ill = 1'b0;
      if (cmd_valid && rdy) begin
         c = cls(cmd_instr);
         if (c == 1) e_ill = 1'b1;
         else if (c >= 2) mq.push_back(cmd_instr);
      end
      exp_vec = {e_host, (mq.size() < DEPTH), e_bv, e_bi, e_idle, e_ill};
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      total++;
      if (dut_vec !== {8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_vals got=%h want=%h", dut_vec,
                  {8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0});
      end
      reset = 1'b0;
      tick();
      total++;
      if (dut_vec !== exp_vec) begin
         bad++;
         $display("FAIL reset_rel got=%h want=%h", dut_vec, exp_vec);
      end
   endtask

   task automatic test_short();
      int first = -1;
      int n = 0;
      cmd_valid = 1'b1;
      cmd_instr = 8'h1C;
      tick();
      cmd_valid = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL short_cyc%0d got=%h want=%h", i, dut_vec, exp_vec);
         end
         if (host_instruction == 8'h1C) begin
            n++;
            if (first < 0) first = i;
         end
      end
      total++;
      if (first != 2 || n != 2) begin
         bad++;
         $display("FAIL short_timing first=%0d n=%0d want 2/2", first, n);
      end
      total++;
      if ({host_instruction, sched_idle} !== {8'h00, 1'b1}) begin
         bad++;
         $display("FAIL short_end host=%h idle=%b want 00/1",
                  host_instruction, sched_idle);
      end
   endtask

   task automatic test_load();
      int nh = 0;
      int nb = 0;
      cmd_valid = 1'b1;
      cmd_instr = 8'h84;
      tick();
      cmd_valid = 1'b0;
      for (int i = 1; i <= 72; i++) begin
         tick();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL load_cyc%0d got=%h want=%h", i, dut_vec, exp_vec);
         end
         if (host_instruction == 8'h84) nh++;
         if (beat_valid) begin
            total++;
            if (beat_idx !== 6'(nb)) begin
               bad++;
               $display("FAIL load_beat got=%0d want=%0d", beat_idx, nb);
            end
            nb++;
         end
      end
      total++;
      if (nh != 65 || nb != 64) begin
         bad++;
         $display("FAIL load_len host=%0d beats=%0d want 65/64", nh, nb);
      end
   endtask

   task automatic test_fill();
      logic [7:0] lst [5];
      int st [$];
      logic [7:0] vals [$];
      logic [7:0] prev;
      lst = '{8'h5C, 8'h65, 8'hA7, 8'hFD, 8'h2E};
      fsm_busy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cmd_valid = 1'b1;
         cmd_instr = lst[k];
         tick();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL fill_push%0d got=%h want=%h", k, dut_vec, exp_vec);
         end
      end
      cmd_instr = lst[4];
      for (int k = 0; k < 3; k++) begin
         total++;
         if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_ready got=%b want=0", cmd_ready);
         end
         tick();
      end
      cmd_valid = 1'b0;
      fsm_busy = 1'b0;
      prev = 8'h00;
      for (int i = 0; i < 30; i++) begin
         tick();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL fill_cyc%0d got=%h want=%h", i, dut_vec, exp_vec);
         end
         if (host_instruction != 8'h00 && prev == 8'h00) begin
            st.push_back(i);
            vals.push_back(host_instruction);
         end
         prev = host_instruction;
      end
      total++;
      if (st.size() != 4) begin
         bad++;
         $display("FAIL fill_count got=%0d want=4", st.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            total++;
            if (vals[k] !== lst[k]) begin
               bad++;
               $display("FAIL fill_order%0d got=%h want=%h", k, vals[k], lst[k]);
            end
            if (k > 0) begin
               total++;
               if (st[k] - st[k-1] != 4) begin
                  bad++;
                  $display("FAIL fill_gap%0d got=%0d want=4", k, st[k] - st[k-1]);
               end
            end
         end
      end
   endtask

   task automatic test_illegal();
      int np = 0;
      int nh = 0;
      cmd_valid = 1'b1;
      cmd_instr = 8'h08;
      tick();
      total++;
      if (illegal_pulse !== 1'b1) begin
         bad++;
         $display("FAIL illegal_pulse got=%b want=1", illegal_pulse);
      end
      np += int'(illegal_pulse);
      cmd_instr = 8'h00;
      tick();
      np += int'(illegal_pulse);
      cmd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL illegal_cyc%0d got=%h want=%h", i, dut_vec, exp_vec);
         end
         np += int'(illegal_pulse);
         if (host_instruction != 8'h00) nh++;
      end
      total++;
      if (np != 1 || nh != 0) begin
         bad++;
         $display("FAIL illegal_drop pulses=%0d issued=%0d want 1/0", np, nh);
      end
   endtask

   task automatic test_reset_mid();
      bit hit = 1'b0;
      int nh = 0;
      cmd_valid = 1'b1;
      cmd_instr = 8'h46;
      tick();
      cmd_instr = 8'h3D;
      tick();
      cmd_instr = 8'h9E;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 120 && !hit; i++) begin
         tick();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL mid_cyc%0d got=%h want=%h", i, dut_vec, exp_vec);
         end
         if (beat_valid && beat_idx == 6'd30) hit = 1'b1;
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL mid_beat30 got=none want=beat 30");
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if ({host_instruction, beat_valid, cmd_ready, sched_idle} !==
          {8'h00, 1'b0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL mid_reset host=%h bv=%b rdy=%b idle=%b want 00/0/1/1",
                  host_instruction, beat_valid, cmd_ready, sched_idle);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         if (host_instruction != 8'h00) nh++;
      end
      total++;
      if (nh != 0) begin
         bad++;
         $display("FAIL mid_flush issued=%0d want=0", nh);
      end
   endtask

`ifdef MPU_SCHED_PERF_CNT_EN
   task automatic test_perf();
      logic [7:0] ops [3];
      ops = '{8'h1C, 8'h25, 8'hDF};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      fsm_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cmd_valid = 1'b1;
         cmd_instr = ops[k];
         tick();
      end
      cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      fsm_busy = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      total++;
      if (ops_issued !== 16'd3 || stall_cycles !== 16'd5) begin
         bad++;
         $display("FAIL perf got=%0d/%0d want 3/5", ops_issued, stall_cycles);
      end
   endtask
`endif

   task automatic test_random();
      int r;
      for (int i = 0; i < 1500; i++) begin
         fsm_busy = ($urandom_range(0, 3) == 0);
         cmd_valid = ($urandom_range(0, 1) == 1);
         r = $urandom_range(0, 99);
         cmd_instr = 8'($urandom);
         if (r < 70) cmd_instr[3:0] = (r % 2 == 0) ? 4'hC | 4'(r % 4) :
                                                      4'h5 | 4'(r % 3 == 0 ? 2 : 0);
         else if (r < 73) cmd_instr[3:0] = (r == 70) ? 4'h4 : 4'h6;
         tick();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL rand_cyc%0d got=%h want=%h", i, dut_vec, exp_vec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_short();
      test_load();
      test_fill();
      test_illegal();
      test_reset_mid();
`ifdef MPU_SCHED_PERF_CNT_EN
      test_perf();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
